// File: rtl/riscv_wb_arbiter_pkg.sv
// riscv_wb_pkg: shared widths, writeback request type and arbiter source ids
package riscv_wb_pkg;
    localparam int XLEN = 32;
    localparam int AW = 5;
    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;
    typedef enum logic {SRC_A, SRC_B} src_e;
endpackage

// File: rtl/riscv_wb_arbiter_if.sv
// riscv_wb_arbiter_if: producer handshakes and register-file write port
interface riscv_wb_arbiter_if;
    import riscv_wb_pkg::*;
    logic            a_valid_i, a_ready_o, b_valid_i, b_ready_o;
    logic [AW-1:0]   a_addr_i, b_addr_i, AddrD_o;
    logic [XLEN-1:0] a_data_i, b_data_i, DataD_o;
    logic            RegWEn_o;
    logic [31:0]     pending_o;
    modport slave (
        input  a_valid_i, a_addr_i, a_data_i, b_valid_i, b_addr_i, b_data_i,
        output a_ready_o, b_ready_o, AddrD_o, DataD_o, RegWEn_o, pending_o
    );
    modport master (
        output a_valid_i, a_addr_i, a_data_i, b_valid_i, b_addr_i, b_data_i,
        input  a_ready_o, b_ready_o, AddrD_o, DataD_o, RegWEn_o, pending_o
    );
endinterface

// File: rtl/riscv_wb_arbiter_fifo.sv
// wb_fifo: synchronous FIFO of writeback requests
// Per-entry valid/addr vectors let the parent build the pending-register mask.
module wb_fifo
    import riscv_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push,
    input  logic                      pop,
    input  wb_req_t                   din,
    output logic                      full,
    output logic                      empty,
    output wb_req_t                   head,
    output logic [DEPTH-1:0]          ent_valid,
    output logic [DEPTH-1:0][AW-1:0]  ent_addr
);
    localparam int PW = $clog2(DEPTH);
    wb_req_t       mem [DEPTH];
    logic [PW-1:0] wr, rd;
    logic [PW:0]   cnt;
    logic          do_push, do_pop;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = cnt == (PW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign head    = mem[rd];
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr] <= din;
    end
    // pop clears before push sets, so a full-FIFO slot reused in one cycle stays valid
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr        <= '0;
            rd        <= '0;
            cnt       <= '0;
            ent_valid <= '0;
        end else begin
            if (do_pop) begin
                rd            <= rd + 1'b1;
                ent_valid[rd] <= 1'b0;
            end
            if (do_push) begin
                wr            <= wr + 1'b1;
                ent_valid[wr] <= 1'b1;
            end
            cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
    always_comb begin
        ent_addr = '0;
        for (int i = 0; i < DEPTH; i++) ent_addr[i] = mem[i].addr;
    end
endmodule

// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter: round-robin merge of ALU and LSU writebacks onto one regfile port
// Define WB_STATS_EN to add saturating conflict and dropped-x0 counters.
module riscv_wb_arbiter
    import riscv_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    riscv_wb_arbiter_if.slave      bus
`ifdef WB_STATS_EN
    ,
    output logic [31:0]            conflict_cnt_o,
    output logic [31:0]            drop_x0_cnt_o
`endif
);
    wb_req_t                  a_din, b_din, a_head, b_head, out_q;
    logic                     a_full, a_empty, b_full, b_empty;
    logic                     a_acc, b_acc, a_drop, b_drop, gnt_a, gnt_b, both, we_q;
    logic [DEPTH-1:0]         a_ev, b_ev;
    logic [DEPTH-1:0][AW-1:0] a_ea, b_ea;
    logic [31:0]              pend;
    src_e                     last_grant;
    assign a_din  = {bus.a_addr_i, bus.a_data_i};
    assign b_din  = {bus.b_addr_i, bus.b_data_i};
    assign a_acc  = bus.a_valid_i & ~a_full;
    assign b_acc  = bus.b_valid_i & ~b_full;
    assign a_drop = a_acc & (bus.a_addr_i == '0);
    assign b_drop = b_acc & (bus.b_addr_i == '0);
    assign both   = ~a_empty & ~b_empty;
    assign gnt_a  = ~a_empty & (b_empty | (last_grant == SRC_B));
    assign gnt_b  = ~b_empty & ~gnt_a;
    wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk_i(clk_i), .rst_i(rst_i), .push(a_acc & ~a_drop), .pop(gnt_a), .din(a_din),
        .full(a_full), .empty(a_empty), .head(a_head), .ent_valid(a_ev), .ent_addr(a_ea)
    );
    wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk_i(clk_i), .rst_i(rst_i), .push(b_acc & ~b_drop), .pop(gnt_b), .din(b_din),
        .full(b_full), .empty(b_empty), .head(b_head), .ent_valid(b_ev), .ent_addr(b_ea)
    );
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            last_grant <= SRC_B;
            we_q       <= 1'b0;
            out_q      <= '0;
        end else begin
            we_q <= gnt_a | gnt_b;
            if (gnt_a | gnt_b) begin
                out_q      <= gnt_a ? a_head : b_head;
                last_grant <= gnt_a ? SRC_A : SRC_B;
            end
        end
    end
    // mask covers both queues and the write currently on the port; x0 never appears
    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a_ev[i]) pend[a_ea[i]] = 1'b1;
            if (b_ev[i]) pend[b_ea[i]] = 1'b1;
        end
        if (we_q) pend[out_q.addr] = 1'b1;
        pend[0] = 1'b0;
    end
    assign bus.a_ready_o = ~a_full;
    assign bus.b_ready_o = ~b_full;
    assign bus.AddrD_o   = out_q.addr;
    assign bus.DataD_o   = out_q.data;
    assign bus.RegWEn_o  = we_q;
    assign bus.pending_o = pend;
`ifdef WB_STATS_EN
    logic [32:0] drop_sum;
    assign drop_sum = {1'b0, drop_x0_cnt_o} + 33'(a_drop) + 33'(b_drop);
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            conflict_cnt_o <= '0;
            drop_x0_cnt_o  <= '0;
        end else begin
            if (both && ~&conflict_cnt_o) conflict_cnt_o <= conflict_cnt_o + 1'b1;
            drop_x0_cnt_o <= drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// tb_riscv_wb_arbiter: directed and randomized checks against a queue-based model
module tb_riscv_wb_arbiter;
    import riscv_wb_pkg::*;
    localparam int DEPTH = 2;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;
    riscv_wb_arbiter_if bus();
`ifdef WB_STATS_EN
    logic [31:0] conflict_cnt, drop_cnt;
`endif
    riscv_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus.slave)
`ifdef WB_STATS_EN
        ,
        .conflict_cnt_o(conflict_cnt),
        .drop_x0_cnt_o(drop_cnt)
`endif
    );
    int      checks = 0;
    int      errors = 0;
    wb_req_t qa[$], qb[$];
    wb_req_t m_out;
    logic    m_we, acc_a, acc_b;
    int      m_last, m_conf, m_drop;
    function automatic logic [31:0] exp_pend();
        logic [31:0] p = '0;
        foreach (qa[i]) p[qa[i].addr] = 1'b1;
        foreach (qb[i]) p[qb[i].addr] = 1'b1;
        if (m_we) p[m_out.addr] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction
    // advance one clock; the model applies the same edge with queue semantics
    task automatic step();
        bit ga, gb;
        @(posedge clk_i);
        if (!rst_i) begin
            qa.delete(); qb.delete();
            m_we = 0; m_out = '0; m_last = 1; m_conf = 0; m_drop = 0; acc_a = 0; acc_b = 0;
        end else begin
            acc_a = bus.a_valid_i && qa.size() < DEPTH;
            acc_b = bus.b_valid_i && qb.size() < DEPTH;
            if (qa.size() > 0 && qb.size() > 0) m_conf++;
            ga = qa.size() > 0 && (qb.size() == 0 || m_last == 1);
            gb = !ga && qb.size() > 0;
            m_we = ga || gb;
            if (ga) begin m_out = qa.pop_front(); m_last = 0; end
            else if (gb) begin m_out = qb.pop_front(); m_last = 1; end
            if (acc_a) begin
                if (bus.a_addr_i != 0) qa.push_back('{addr: bus.a_addr_i, data: bus.a_data_i});
                else m_drop++;
            end
            if (acc_b) begin
                if (bus.b_addr_i != 0) qb.push_back('{addr: bus.b_addr_i, data: bus.b_data_i});
                else m_drop++;
            end
        end
        #1;
    endtask
    task automatic idle_inputs();
        bus.a_valid_i = 0; bus.a_addr_i = '0; bus.a_data_i = '0;
        bus.b_valid_i = 0; bus.b_addr_i = '0; bus.b_data_i = '0;
    endtask
    task automatic do_reset();
        idle_inputs();
        rst_i = 0; step(); step();
        rst_i = 1;
    endtask
    task automatic test_reset();
        rst_i = 0;
        bus.a_valid_i = 1; bus.a_addr_i = 5'd7; bus.a_data_i = 32'h1;
        bus.b_valid_i = 1; bus.b_addr_i = 5'd9; bus.b_data_i = 32'h2;
        step(); step();
        checks += 6;
        if (bus.RegWEn_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", bus.RegWEn_o); end
        if (bus.AddrD_o !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", bus.AddrD_o); end
        if (bus.DataD_o !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.DataD_o); end
        if (bus.pending_o !== 32'd0) begin errors++; $display("FAIL reset_pend got %h exp 0", bus.pending_o); end
        if (bus.a_ready_o !== 1'b1) begin errors++; $display("FAIL reset_a_ready got %b exp 1", bus.a_ready_o); end
        if (bus.b_ready_o !== 1'b1) begin errors++; $display("FAIL reset_b_ready got %b exp 1", bus.b_ready_o); end
        idle_inputs();
        rst_i = 1;
        step();
        checks += 2;
        if (bus.RegWEn_o !== 1'b0) begin errors++; $display("FAIL reset_noacc_we got %b exp 0", bus.RegWEn_o); end
        if (bus.pending_o !== 32'd0) begin errors++; $display("FAIL reset_noacc_pend got %h exp 0", bus.pending_o); end
`ifdef WB_STATS_EN
        checks++;
        if (conflict_cnt !== 0 || drop_cnt !== 0) begin errors++; $display("FAIL reset_stats got %0d/%0d exp 0/0", conflict_cnt, drop_cnt); end
`endif
    endtask
    task automatic test_single();
        bus.a_valid_i = 1; bus.a_addr_i = 5'd5; bus.a_data_i = 32'hDEADBEEF;
        step();
        idle_inputs();
        checks += 2;
        if (bus.pending_o !== 32'h20) begin errors++; $display("FAIL single_pend_n got %h exp 20", bus.pending_o); end
        if (bus.RegWEn_o !== 1'b0) begin errors++; $display("FAIL single_we_n got %b exp 0", bus.RegWEn_o); end
        step();
        checks += 4;
        if (bus.RegWEn_o !== 1'b1) begin errors++; $display("FAIL single_we got %b exp 1", bus.RegWEn_o); end
        if (bus.AddrD_o !== 5'd5) begin errors++; $display("FAIL single_addr got %0d exp 5", bus.AddrD_o); end
        if (bus.DataD_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", bus.DataD_o); end
        if (bus.pending_o !== 32'h20) begin errors++; $display("FAIL single_pend_n1 got %h exp 20", bus.pending_o); end
        step();
        checks += 3;
        if (bus.RegWEn_o !== 1'b0) begin errors++; $display("FAIL single_we_n2 got %b exp 0", bus.RegWEn_o); end
        if (bus.pending_o !== 32'h0) begin errors++; $display("FAIL single_pend_n2 got %h exp 0", bus.pending_o); end
        if (bus.AddrD_o !== 5'd5) begin errors++; $display("FAIL single_hold got %0d exp 5", bus.AddrD_o); end
    endtask
    task automatic test_conflict();
        logic [4:0]  ea [4] = '{5'd3, 5'd4, 5'd5, 5'd6};
        logic [31:0] ed [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_reset();
        bus.a_valid_i = 1; bus.a_addr_i = 5'd3; bus.a_data_i = 32'h11;
        bus.b_valid_i = 1; bus.b_addr_i = 5'd4; bus.b_data_i = 32'h22;
        step();
        bus.a_addr_i = 5'd5; bus.a_data_i = 32'h33;
        bus.b_addr_i = 5'd6; bus.b_data_i = 32'h44;
        for (int i = 0; i < 4; i++) begin
            step();
            idle_inputs();
            checks++;
            if (bus.RegWEn_o !== 1'b1 || bus.AddrD_o !== ea[i] || bus.DataD_o !== ed[i]) begin
                errors++;
                $display("FAIL conflict_order[%0d] got we=%b x%0d %h exp we=1 x%0d %h", i, bus.RegWEn_o, bus.AddrD_o, bus.DataD_o, ea[i], ed[i]);
            end
        end
        step();
        checks++;
        if (bus.RegWEn_o !== 1'b0) begin errors++; $display("FAIL conflict_idle got %b exp 0", bus.RegWEn_o); end
    endtask
    task automatic test_back_to_back();
        int na = 1, nb = 16, prev = -1, seen = 0, pushed = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            bus.a_valid_i = c < 8; bus.a_addr_i = 5'(na); bus.a_data_i = 32'hA000 + 32'(na);
            bus.b_valid_i = c < 8; bus.b_addr_i = 5'(nb); bus.b_data_i = 32'hB000 + 32'(nb);
            step();
            if (acc_a) begin na = na % 15 + 1; pushed++; end
            if (acc_b) begin nb = nb == 31 ? 16 : nb + 1; pushed++; end
            checks += 3;
            if (bus.RegWEn_o !== m_we) begin errors++; $display("FAIL b2b_we c%0d got %b exp %b", c, bus.RegWEn_o, m_we); end
            if (m_we && {bus.AddrD_o, bus.DataD_o} !== m_out) begin errors++; $display("FAIL b2b_data c%0d got x%0d %h exp x%0d %h", c, bus.AddrD_o, bus.DataD_o, m_out.addr, m_out.data); end
            if ({bus.a_ready_o, bus.b_ready_o} !== {qa.size() < DEPTH, qb.size() < DEPTH}) begin
                errors++; $display("FAIL b2b_ready c%0d got %b%b exp %b%b", c, bus.a_ready_o, bus.b_ready_o, qa.size() < DEPTH, qb.size() < DEPTH);
            end
            if (bus.RegWEn_o === 1'b1) begin
                seen++;
                if (c < 9) begin
                    checks++;
                    if (int'(bus.AddrD_o[4]) == prev) begin errors++; $display("FAIL b2b_alternate c%0d got src %0d exp %0d", c, bus.AddrD_o[4], 1 - prev); end
                end
                prev = int'(bus.AddrD_o[4]);
            end
        end
        checks++;
        if (seen != pushed) begin errors++; $display("FAIL b2b_count got %0d exp %0d", seen, pushed); end
    endtask
    task automatic test_x0();
        do_reset();
        bus.a_valid_i = 1; bus.a_addr_i = 5'd0; bus.a_data_i = 32'hFFFFFFFF;
        step();
        idle_inputs();
        checks++;
        if (!acc_a || bus.a_ready_o !== 1'b1) begin errors++; $display("FAIL x0_accept got ready %b exp 1", bus.a_ready_o); end
        for (int c = 0; c < 3; c++) begin
            checks += 2;
            if (bus.RegWEn_o !== 1'b0) begin errors++; $display("FAIL x0_we c%0d got %b exp 0", c, bus.RegWEn_o); end
            if (bus.pending_o !== 32'd0) begin errors++; $display("FAIL x0_pend c%0d got %h exp 0", c, bus.pending_o); end
            step();
        end
`ifdef WB_STATS_EN
        checks++;
        if (drop_cnt !== 32'd1) begin errors++; $display("FAIL x0_stat got %0d exp 1", drop_cnt); end
`endif
    endtask
    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!(bus.a_valid_i && !acc_a)) begin
                bus.a_valid_i = 1'($urandom_range(0, 1));
                bus.a_addr_i  = $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
                bus.a_data_i  = $urandom;
            end
            if (!(bus.b_valid_i && !acc_b)) begin
                bus.b_valid_i = 1'($urandom_range(0, 1));
                bus.b_addr_i  = $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
                bus.b_data_i  = $urandom;
            end
            step();
            checks += 4;
            if (bus.RegWEn_o !== m_we) begin errors++; $display("FAIL rnd_we c%0d got %b exp %b", c, bus.RegWEn_o, m_we); end
            if ({bus.AddrD_o, bus.DataD_o} !== m_out) begin errors++; $display("FAIL rnd_port c%0d got x%0d %h exp x%0d %h", c, bus.AddrD_o, bus.DataD_o, m_out.addr, m_out.data); end
            if (bus.pending_o !== exp_pend()) begin errors++; $display("FAIL rnd_pend c%0d got %h exp %h", c, bus.pending_o, exp_pend()); end
            if ({bus.a_ready_o, bus.b_ready_o} !== {qa.size() < DEPTH, qb.size() < DEPTH}) begin
                errors++; $display("FAIL rnd_ready c%0d got %b%b exp %b%b", c, bus.a_ready_o, bus.b_ready_o, qa.size() < DEPTH, qb.size() < DEPTH);
            end
`ifdef WB_STATS_EN
            checks++;
            if (conflict_cnt !== 32'(m_conf) || drop_cnt !== 32'(m_drop)) begin
                errors++; $display("FAIL rnd_stats c%0d got %0d/%0d exp %0d/%0d", c, conflict_cnt, drop_cnt, m_conf, m_drop);
            end
`endif
        end
    endtask
    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            bus.a_valid_i = 1; bus.a_addr_i = 5'(1 + c); bus.a_data_i = 32'(c);
            bus.b_valid_i = 1; bus.b_addr_i = 5'(17 + c); bus.b_data_i = 32'(c + 100);
            step();
        end
        checks++;
        if (bus.pending_o !== exp_pend() || qa.size() + qb.size() == 0) begin errors++; $display("FAIL mid_prefill got %h exp %h", bus.pending_o, exp_pend()); end
        rst_i = 0;
        step();
        rst_i = 1;
        idle_inputs();
        checks += 4;
        if (bus.RegWEn_o !== 1'b0) begin errors++; $display("FAIL mid_we got %b exp 0", bus.RegWEn_o); end
        if (bus.pending_o !== 32'd0) begin errors++; $display("FAIL mid_pend got %h exp 0", bus.pending_o); end
        if ({bus.a_ready_o, bus.b_ready_o} !== 2'b11) begin errors++; $display("FAIL mid_ready got %b%b exp 11", bus.a_ready_o, bus.b_ready_o); end
        if (bus.AddrD_o !== 5'd0) begin errors++; $display("FAIL mid_addr got %0d exp 0", bus.AddrD_o); end
`ifdef WB_STATS_EN
        checks++;
        if (conflict_cnt !== 0 || drop_cnt !== 0) begin errors++; $display("FAIL mid_stats got %0d/%0d exp 0/0", conflict_cnt, drop_cnt); end
`endif
        step();
        checks++;
        if (bus.RegWEn_o !== 1'b0 || bus.pending_o !== 32'd0) begin errors++; $display("FAIL mid_drained got we=%b pend=%h exp 0/0", bus.RegWEn_o, bus.pending_o); end
    endtask
    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_conflict();
        test_back_to_back();
        test_x0();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
